gp_reg_bank: RTL
================

Name: gp_reg_bank

Overview:
Parametrised general-purpose register bank for the CPU datapath. It generalises the fixed 16 x 32-bit R0-R15 set to configurable width and depth. It adds two independent read ports, R0 base-address gating, per-register dirty tracking, and a sequential bulk-clear engine. It sits between the bus/select-encode logic and the ALU operand paths.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of registers; power of two, >= 2
ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override)

Ports:
Clock  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write register index
wr_data  input  DATA_W  write data (normally the bus output)
rd_addr_a  input  ADDR_W  read port A index
rd_data_a  output  DATA_W  read port A data (combinational)
rd_addr_b  input  ADDR_W  read port B index
rd_data_b  output  DATA_W  read port B data (combinational)
BAout  input  1  base-address mode: reads of index 0 return zero
clear_req  input  1  start bulk clear (level-sampled)
busy  output  1  bulk clear in progress
wr_drop  output  1  one-cycle pulse: a write was rejected because busy was 1
dirty  output  NUM_REGS  bit i = 1 if register i has been written since the last reset or clear

Behaviour:
- Reset (clr=0, asynchronous):
  - all registers = 0; dirty = 0; busy = 0; wr_drop = 0.
  - FSM = IDLE; sweep index = 0.
  - Takes effect immediately, including mid-sweep.
- Write:
  - On a rising edge with wr_en=1 and busy=0: reg[wr_addr] <= wr_data and dirty[wr_addr] <= 1.
  - Write latency is 1 cycle.
  - R0 is a normal storage register; BAout affects reads only.
- Read:
  - rd_data_x = reg[rd_addr_x], except 0 when BAout=1 and rd_addr_x=0.
  - Ports A and B are fully independent and may address the same register.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on an edge with clear_req=1. Sweep index <= 0 and busy <= 1 from the next cycle.
  - In CLEAR, each edge: reg[idx] <= 0, dirty[idx] <= 0, idx <= idx+1.
  - When idx = NUM_REGS-1: that register is cleared, then CLEAR -> IDLE and busy <= 0.
  - busy is high for exactly NUM_REGS cycles.
  - clear_req while in CLEAR is ignored and does not restart the sweep.
  - clear_req held high at sweep end starts a new sweep on the following edge.
- Writes while busy=1:
  - Dropped: no register or dirty change.
  - wr_drop = 1 for the one cycle after the dropped edge, then 0.
- Edge with clear_req=1 and wr_en=1 in IDLE:
  - The write commits (busy is still 0 on that edge).
  - The sweep then starts and later clears that register.
- Reads during CLEAR return current contents: already-swept registers read 0, unswept registers hold old values.
- The sweep index wraps naturally at NUM_REGS; no out-of-range index is reachable.

Optional Feature:
- Macro: GP_REG_BANK_BYPASS_EN.
- With the macro defined:
  - If wr_en=1, busy=0 and wr_addr = rd_addr_x, then rd_data_x = wr_data in the same cycle (write-to-read forwarding).
  - BAout zeroing of index 0 still takes precedence over forwarding.
- Without the macro: reads return the stored value; new data is visible only after the write edge.

Test Plan:
- Reset then write 0xDEADBEEF to R5, read A=5, B=5 -> both 0xDEADBEEF the cycle after the write; dirty = 0x0020.
- Write 0x00001234 to R0; BAout=1, read A=0 -> 0x00000000; BAout=0 -> 0x00001234.
- Fill R0-R15 with i+1; pulse clear_req for 1 cycle:
  - busy high for exactly 16 cycles;
  - at sweep cycle 3, R0-R2 read 0 and R3 reads 4;
  - at end, all registers = 0 and dirty = 0.
- During CLEAR, wr_en=1, wr_addr=7, wr_data=0xAA -> wr_drop pulses 1 cycle; R7 = 0 after the sweep; dirty[7] = 0.
- Mid-sweep (cycle 8), assert clr=0 for 1 cycle -> busy = 0 immediately, all registers = 0; a subsequent write to R3 succeeds.
- With GP_REG_BANK_BYPASS_EN: wr_en=1, wr_addr=9, wr_data=0x55AA55AA, rd_addr_a=9 -> rd_data_a = 0x55AA55AA before the edge. Without the macro: old R9 value before the edge, new value after.

Source files
------------

// File: rtl/gp_reg_bank.sv
// gp_reg_bank: parametrised general-purpose register bank for the CPU datapath.
//
// It stores NUM_REGS registers of DATA_W bits each. It has one write port, two
// independent combinational read ports, R0 base-address gating on reads,
// per-register dirty tracking, and a sequential bulk-clear engine that sweeps
// one register per cycle.
//
// Optional feature (compile-time macro GP_REG_BANK_BYPASS_EN):
//   When defined, a write in progress is forwarded to a read port that
//   addresses the same register in the same cycle. BAout zeroing of index 0
//   still takes precedence over forwarding.
//
// Ports:
//   Clock      in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   wr_en      in   write strobe
//   wr_addr    in   write register index                [ADDR_W]
//   wr_data    in   write data                          [DATA_W]
//   rd_addr_a  in   read port A index                   [ADDR_W]
//   rd_data_a  out  read port A data (combinational)    [DATA_W]
//   rd_addr_b  in   read port B index                   [ADDR_W]
//   rd_data_b  out  read port B data (combinational)    [DATA_W]
//   BAout      in   base-address mode: reads of index 0 return zero
//   clear_req  in   start bulk clear (level-sampled)
//   busy       out  bulk clear in progress (registered)
//   wr_drop    out  one-cycle pulse after a write rejected while busy (registered)
//   dirty      out  bit i set if register i written since last reset/clear [NUM_REGS]
module gp_reg_bank #(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  input  logic                BAout,
  input  logic                clear_req,
  output logic                busy,
  output logic                wr_drop,
  output logic [NUM_REGS-1:0] dirty
);

`ifdef GP_REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                wr_drop_q, wr_drop_d;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  // State, sweep index, storage and status registers.
  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      dirty_q   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      dirty_q   <= dirty_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Next-state: writes in IDLE, one-register-per-cycle sweep in CLEAR.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_drop_d = 1'b0;
    dirty_d   = dirty_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        // The write on the starting edge still commits; the sweep clears it later.
        if (wr_en) begin
          regs_d[wr_addr]  = wr_data;
          dirty_d[wr_addr] = 1'b1;
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Writes are dropped; clear_req is ignored until the sweep ends.
        wr_drop_d       = wr_en;
        regs_d[idx_q]   = '0;
        dirty_d[idx_q]  = 1'b0;
        idx_d           = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  // Read ports: optional forwarding first, BAout gating of index 0 last.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (BYPASS && wr_en && !busy_q) begin
      if (wr_addr == rd_addr_a) rd_data_a = wr_data;
      if (wr_addr == rd_addr_b) rd_data_b = wr_data;
    end
    if (BAout && (rd_addr_a == '0)) rd_data_a = '0;
    if (BAout && (rd_addr_b == '0)) rd_data_b = '0;
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;
  assign dirty   = dirty_q;

endmodule
